// File: rtl/freq_meter_pkg.sv
// Shared constants and elaboration-time helpers for the gated frequency meter.
package freq_meter_pkg;

    // Board system clock; the default gate is one second, so the published count reads in Hz.
    localparam int unsigned CLK_HZ = 50_000_000;

    // Bits needed to hold 0..value-1; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/freq_meter_if.sv
// Measurement-side signals of the frequency meter: input under test, hold, and published result.
interface freq_meter_if #(
    parameter int unsigned CNT_W = 16
) ();

    logic             sig_in;
    logic             hold;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             valid;

    modport master (
        output sig_in,
        output hold,
        input  count,
        input  overflow,
        input  valid
    );

    modport slave (
        input  sig_in,
        input  hold,
        output count,
        output overflow,
        output valid
    );

endinterface

// File: rtl/freq_meter_sync_edge.sv
// Two-flop synchronizer plus previous-value register; pulses rise for one clk per rising edge.
module freq_meter_sync_edge (
    input  logic clk,
    input  logic clr,
    input  logic async_in,
    output logic rise
);

    logic s0_q;
    logic s1_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            s0_q   <= 1'b0;
            s1_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s0_q   <= async_in;
            s1_q   <= s0_q;
            prev_q <= s1_q;
        end
    end

    // prev starts at 0, so an input already high at reset release reads as one edge.
    assign rise = s1_q & ~prev_q;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clocks, publishes per window.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = CLK_HZ,
    parameter int unsigned CNT_W       = 16
) (
    input logic          clk,
    input logic          clr,
    freq_meter_if.slave  bus
);

    localparam int unsigned      WIN_W    = clog2(GATE_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             rise;
    logic             terminal;
    logic [WIN_W-1:0] wcnt_q;
    logic [CNT_W-1:0] ecnt_q;
    logic             ovf_q;
    logic [CNT_W-1:0] ecnt_d;
    logic             ovf_d;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             valid_q;

    freq_meter_sync_edge u_sync_edge (
        .clk      (clk),
        .clr      (clr),
        .async_in (bus.sig_in),
        .rise     (rise)
    );

    // Saturating edge count including this cycle's rise; on the terminal cycle this is the total.
    always_comb begin
        terminal = (wcnt_q == WIN_LAST);
        ecnt_d   = ecnt_q;
        ovf_d    = ovf_q;
        if (rise) begin
            if (ecnt_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                ecnt_d = ecnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            wcnt_q     <= '0;
            ecnt_q     <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (terminal) begin
                // Windows run back to back: the next one starts clean on the following cycle.
                wcnt_q <= '0;
                ecnt_q <= '0;
                ovf_q  <= 1'b0;
                if (!bus.hold) begin
                    count_q    <= ecnt_d;
                    overflow_q <= ovf_d;
                    valid_q    <= 1'b1;
                end
            end else begin
                wcnt_q <= wcnt_q + WIN_W'(1);
                ecnt_q <= ecnt_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.valid    = valid_q;

endmodule
